// File: rtl/rvs_lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rvs_lsu_pkg
// Purpose  : Shared types and default widths for the scalar-side LSU
//            responder (request/response payload structs).
// Ports    : n/a (package)
// Revision : 1.0 - initial release
// ============================================================================
package rvs_lsu_pkg;

   localparam int RVS_LSU_TAG_W  = 4;
   localparam int RVS_LSU_ADDR_W = 4;
   localparam int RVS_LSU_DATA_W = 128;
   localparam int RVS_LSU_VD_W   = 5;

   typedef struct packed {
      logic [RVS_LSU_TAG_W-1:0]  tag;
      logic                      is_load;
      logic [RVS_LSU_ADDR_W-1:0] addr;
      logic [RVS_LSU_VD_W-1:0]   vd;
      logic [RVS_LSU_DATA_W-1:0] wdata;
   } lsu_req_t;

   typedef struct packed {
      logic [RVS_LSU_TAG_W-1:0]  tag;
      logic                      is_load;
      logic [RVS_LSU_VD_W-1:0]   vd;
      logic [RVS_LSU_DATA_W-1:0] rdata;
   } lsu_resp_t;

endpackage
`default_nettype wire

// File: rtl/rvs_lsu_responder_if.sv
`default_nettype none
// ============================================================================
// Module   : rvs_lsu_responder_if
// Purpose  : Request/response handshake bundle between the vector backend
//            (master) and the scalar-side LSU responder (slave).
// Ports    : request  valid/payload/ready (rvv2rvs direction)
//            response valid/payload/ready (rvs2rvv direction)
// Revision : 1.0 - initial release
// ============================================================================
interface rvs_lsu_responder_if;
   import rvs_lsu_pkg::*;

   logic      uop_valid_lsu_rvv2rvs;
   lsu_req_t  uop_lsu_rvv2rvs;
   logic      uop_ready_lsu_rvs2rvv;
   logic      uop_valid_lsu_rvs2rvv;
   lsu_resp_t uop_lsu_rvs2rvv;
   logic      uop_ready_rvv2rvs;

   modport master (
      output uop_valid_lsu_rvv2rvs, uop_lsu_rvv2rvs, uop_ready_rvv2rvs,
      input  uop_ready_lsu_rvs2rvv, uop_valid_lsu_rvs2rvv, uop_lsu_rvs2rvv
   );

   modport slave (
      input  uop_valid_lsu_rvv2rvs, uop_lsu_rvv2rvs, uop_ready_rvv2rvs,
      output uop_ready_lsu_rvs2rvv, uop_valid_lsu_rvs2rvv, uop_lsu_rvs2rvv
   );

endinterface
`default_nettype wire

// File: rtl/rvs_lsu_fifo.sv
`default_nettype none
// ============================================================================
// Module   : rvs_lsu_fifo
// Purpose  : In-order completion FIFO holding {lsu_resp_t, age} per slot.
//            Ages are loaded with 1 on push and stepped by the parent via a
//            per-slot increment enable.
// Ports    : clk, rst_n         - clock, async active-low reset
//            push_i/push_resp_i - write one entry at the tail
//            pop_i              - retire the head entry
//            age_inc_i          - per-slot age increment enables
//            ages_o             - all slot ages, slot i at [i*AGE_W +: AGE_W]
//            head_resp_o/_age_o - head slot contents
//            count_o/full_o/empty_o - occupancy status
// Revision : 1.0 - initial release
// ============================================================================
module rvs_lsu_fifo
   import rvs_lsu_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AGE_W = 2
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        push_i,
   input  lsu_resp_t                   push_resp_i,
   input  logic                        pop_i,
   input  logic [DEPTH-1:0]            age_inc_i,
   output logic [DEPTH*AGE_W-1:0]      ages_o,
   output lsu_resp_t                   head_resp_o,
   output logic [AGE_W-1:0]            head_age_o,
   output logic [$clog2(DEPTH):0]      count_o,
   output logic                        full_o,
   output logic                        empty_o
);
   localparam int c_PTR_W = $clog2(DEPTH);

   logic [c_PTR_W-1:0] wptr_q, wptr_d;
   logic [c_PTR_W-1:0] rptr_q, rptr_d;
   logic [c_PTR_W:0]   count_q, count_d;
   lsu_resp_t          w_resp_arr [DEPTH];
   logic [AGE_W-1:0]   w_age_arr  [DEPTH];

   for (genvar i = 0; i < DEPTH; i++) begin : g_slot
      lsu_resp_t        resp_q;
      logic [AGE_W-1:0] age_q;

      // A push always targets a free slot, so it takes priority over aging.
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            resp_q <= '0;
            age_q  <= '0;
         end else if (push_i && (wptr_q == c_PTR_W'(i))) begin
            resp_q <= push_resp_i;
            age_q  <= AGE_W'(1);
         end else if (age_inc_i[i]) begin
            age_q  <= age_q + 1'b1;
         end
      end

      assign w_resp_arr[i]              = resp_q;
      assign w_age_arr[i]               = age_q;
      assign ages_o[i*AGE_W +: AGE_W]   = age_q;
   end

   always_comb begin
      wptr_d  = wptr_q;
      rptr_d  = rptr_q;
      count_d = count_q;
      if (push_i) wptr_d = wptr_q + 1'b1;
      if (pop_i)  rptr_d = rptr_q + 1'b1;
      unique case ({push_i, pop_i})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
      end
   end

   assign head_resp_o = w_resp_arr[rptr_q];
   assign head_age_o  = w_age_arr[rptr_q];
   assign count_o     = count_q;
   assign full_o      = (count_q == (c_PTR_W+1)'(DEPTH));
   assign empty_o     = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/rvs_lsu_responder.sv
`default_nettype none
// ============================================================================
// Module   : rvs_lsu_responder
// Purpose  : Scalar-side LSU stand-in. Executes vector load/store uops in
//            acceptance order against an internal word memory and returns
//            one in-order completion per uop after a fixed latency.
// Ports    : clk    - clock
//            rst_n  - asynchronous active-low reset
//            lsu_if - slave side of the request/response handshake bundle
// Revision : 1.0 - initial release
// ============================================================================
module rvs_lsu_responder
   import rvs_lsu_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int LATENCY   = 3,
   parameter int MEM_WORDS = 16,
   parameter int DATA_W    = RVS_LSU_DATA_W,
   parameter int TAG_W     = RVS_LSU_TAG_W
) (
   input  logic               clk,
   input  logic               rst_n,
   rvs_lsu_responder_if.slave lsu_if
);
   localparam int c_ADDR_W = $clog2(MEM_WORDS);
   localparam int c_PTR_W  = $clog2(DEPTH);
   localparam int c_AGE_W  = $clog2(LATENCY + 1);

   logic [DATA_W-1:0]        mem_q [MEM_WORDS];
   lsu_req_t                 w_req;
   lsu_resp_t                w_push_resp;
   lsu_resp_t                w_head_resp;
   logic [c_ADDR_W-1:0]      w_addr;
   logic                     w_push;
   logic                     w_pop;
   logic                     w_full;
   logic                     w_empty;
   logic                     w_req_ready;
   logic                     w_resp_valid;
   logic [c_PTR_W:0]         w_count;
   logic [DEPTH*c_AGE_W-1:0] w_ages;
   logic [DEPTH-1:0]         w_age_inc;
   logic [c_AGE_W-1:0]       w_head_age;

   assign w_req  = lsu_if.uop_lsu_rvv2rvs;
   assign w_addr = c_ADDR_W'(w_req.addr);

   // No bypass: a pop in the same cycle never frees space for a push.
   assign w_req_ready = rst_n & ~w_full;
   assign w_push      = lsu_if.uop_valid_lsu_rvv2rvs & w_req_ready;

   // Only the head may respond; younger entries wait even when mature.
   assign w_resp_valid = ~w_empty & (w_head_age == c_AGE_W'(LATENCY));
   assign w_pop        = w_resp_valid & lsu_if.uop_ready_rvv2rvs;

   // Loads read the memory as it stands before the accepting edge, which
   // already reflects every store accepted earlier.
   always_comb begin
      w_push_resp         = '0;
      w_push_resp.tag     = w_req.tag[TAG_W-1:0];
      w_push_resp.is_load = w_req.is_load;
      w_push_resp.vd      = w_req.vd;
      w_push_resp.rdata   = w_req.is_load ? mem_q[w_addr] : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int w = 0; w < MEM_WORDS; w++) mem_q[w] <= '0;
      end else if (w_push && !w_req.is_load) begin
         mem_q[w_addr] <= w_req.wdata;
      end
   end

   // Age 0 marks a slot never written since reset; saturated slots stop.
   for (genvar i = 0; i < DEPTH; i++) begin : g_age_inc
      logic [c_AGE_W-1:0] w_age;
      assign w_age        = w_ages[i*c_AGE_W +: c_AGE_W];
      assign w_age_inc[i] = (w_age != '0) && (w_age != c_AGE_W'(LATENCY));
   end

   rvs_lsu_fifo #(
      .DEPTH (DEPTH),
      .AGE_W (c_AGE_W)
   ) u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (w_push),
      .push_resp_i (w_push_resp),
      .pop_i       (w_pop),
      .age_inc_i   (w_age_inc),
      .ages_o      (w_ages),
      .head_resp_o (w_head_resp),
      .head_age_o  (w_head_age),
      .count_o     (w_count),
      .full_o      (w_full),
      .empty_o     (w_empty)
   );

   assign lsu_if.uop_ready_lsu_rvs2rvv = w_req_ready;
   assign lsu_if.uop_valid_lsu_rvs2rvv = w_resp_valid;
   assign lsu_if.uop_lsu_rvs2rvv       = w_head_resp;

   // Occupancy flags must always agree with the occupancy counter.
   a_count_flags : assert property (@(posedge clk) disable iff (!rst_n)
      (w_full == (w_count == (c_PTR_W+1)'(DEPTH))) && (w_empty == (w_count == '0)));

endmodule
`default_nettype wire

// File: tb/tb_rvs_lsu_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_rvs_lsu_responder
// Purpose  : Self-checking bench for rvs_lsu_responder: directed vector
//            table, hand-written multi-cycle sequences and randomized
//            traffic against a queue-based reference model.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rvs_lsu_responder;
   import rvs_lsu_pkg::*;

   localparam int DEPTH     = 4;
   localparam int LATENCY   = 3;
   localparam int MEM_WORDS = 16;

   logic clk;
   logic rst_n;
   int   n_pass;
   int   n_total;
   int   cyc;

   rvs_lsu_responder_if lsu_if ();

   rvs_lsu_responder #(
      .DEPTH     (DEPTH),
      .LATENCY   (LATENCY),
      .MEM_WORDS (MEM_WORDS),
      .DATA_W    (RVS_LSU_DATA_W),
      .TAG_W     (RVS_LSU_TAG_W)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .lsu_if (lsu_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: queue of pending completions, each stamped with the
   // edge number that accepted it, plus a plain array memory.
   typedef struct {
      lsu_resp_t r;
      int        acc;
   } ent_t;
   ent_t         q[$];
   logic [127:0] mem_m [MEM_WORDS];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
   endtask

   function automatic lsu_req_t mkreq(input logic [3:0] tag, input logic ld,
                                      input logic [3:0] addr, input logic [4:0] vd,
                                      input logic [127:0] wd);
      lsu_req_t r;
      r.tag = tag; r.is_load = ld; r.addr = addr; r.vd = vd; r.wdata = wd;
      return r;
   endfunction

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic model_clear();
      q.delete();
      for (int w = 0; w < MEM_WORDS; w++) mem_m[w] = '0;
      cyc = 0;
   endtask

   // Entered and left at a falling edge; holds reset across one rising edge.
   task automatic do_reset();
      rst_n = 1'b0;
      lsu_if.uop_valid_lsu_rvv2rvs = 1'b0;
      lsu_if.uop_lsu_rvv2rvs       = '0;
      lsu_if.uop_ready_rvv2rvs     = 1'b0;
      #1;
      chk("rst_resp_valid", 256'(lsu_if.uop_valid_lsu_rvs2rvv), 256'(0));
      chk("rst_req_ready",  256'(lsu_if.uop_ready_lsu_rvs2rvv), 256'(0));
      chk("rst_payload",    256'(lsu_if.uop_lsu_rvs2rvv),       256'(0));
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_clear();
   endtask

   // One cycle: drive, compare against the model, advance the model, clock.
   task automatic step(input bit iv, input lsu_req_t rq, input bit rr,
                       output bit acc, output bit dacc, output bit dfire);
      bit        m_rdy, m_vld;
      lsu_resp_t nr;
      lsu_if.uop_valid_lsu_rvv2rvs = iv;
      lsu_if.uop_lsu_rvv2rvs       = rq;
      lsu_if.uop_ready_rvv2rvs     = rr;
      #1;
      m_rdy = (q.size() < DEPTH);
      m_vld = (q.size() != 0) && (cyc >= q[0].acc + LATENCY - 1);
      chk("req_ready",  256'(lsu_if.uop_ready_lsu_rvs2rvv), 256'(m_rdy));
      chk("resp_valid", 256'(lsu_if.uop_valid_lsu_rvs2rvv), 256'(m_vld));
      if (m_vld) chk("resp_payload", 256'(lsu_if.uop_lsu_rvs2rvv), 256'(q[0].r));
      dacc  = iv && lsu_if.uop_ready_lsu_rvs2rvv;
      dfire = rr && lsu_if.uop_valid_lsu_rvs2rvv;
      acc   = iv && m_rdy;
      if (m_vld && rr) void'(q.pop_front());
      if (acc) begin
         nr.tag     = rq.tag;
         nr.is_load = rq.is_load;
         nr.vd      = rq.vd;
         nr.rdata   = rq.is_load ? mem_m[rq.addr] : 128'h0;
         if (!rq.is_load) mem_m[rq.addr] = rq.wdata;
         q.push_back('{r: nr, acc: cyc + 1});
      end
      @(posedge clk);
      cyc++;
      @(negedge clk);
   endtask

   typedef struct {
      bit           iv;
      bit           ld;
      logic [3:0]   tag;
      logic [3:0]   addr;
      logic [4:0]   vd;
      logic [127:0] wd;
      bit           rr;
      bit           e_rdy;
      bit           e_vld;
      logic [3:0]   e_tag;
      bit           e_ld;
      logic [4:0]   e_vd;
      logic [127:0] e_rd;
   } vec_t;

   function automatic vec_t mkv(bit iv, bit ld, logic [3:0] tag, logic [3:0] addr,
                                logic [4:0] vd, logic [127:0] wd, bit rr, bit e_rdy,
                                bit e_vld, logic [3:0] e_tag, bit e_ld,
                                logic [4:0] e_vd, logic [127:0] e_rd);
      vec_t v;
      v.iv = iv; v.ld = ld; v.tag = tag; v.addr = addr; v.vd = vd; v.wd = wd;
      v.rr = rr; v.e_rdy = e_rdy; v.e_vld = e_vld; v.e_tag = e_tag;
      v.e_ld = e_ld; v.e_vd = e_vd; v.e_rd = e_rd;
      return v;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t         tbl [16];
      logic [127:0] a5;
      bit           acc, dacc, dfire;
      int           sent, fires, accs;
      lsu_req_t     idle;

      n_pass  = 0;
      n_total = 0;
      rst_n   = 1'b0;
      a5      = {16{8'hA5}};
      idle    = '0;
      lsu_if.uop_valid_lsu_rvv2rvs = 1'b0;
      lsu_if.uop_lsu_rvv2rvs       = '0;
      lsu_if.uop_ready_rvv2rvs     = 1'b0;

      // ---- directed table: one row per cycle, row 0 is the first cycle out of reset
      //               iv ld tag addr vd  wdata        rr rdy vld etag eld evd  erdata
      tbl[0]  = mkv(1, 0, 1, 3,  0, a5,          1, 1, 0, 0, 0, 0, 0);
      tbl[1]  = mkv(0, 0, 0, 0,  0, 0,           1, 1, 0, 0, 0, 0, 0);
      tbl[2]  = mkv(0, 0, 0, 0,  0, 0,           1, 1, 0, 0, 0, 0, 0);
      tbl[3]  = mkv(0, 0, 0, 0,  0, 0,           1, 1, 1, 1, 0, 0, 0);
      tbl[4]  = mkv(1, 0, 3, 3,  0, 128'h1234,   1, 1, 0, 0, 0, 0, 0);
      tbl[5]  = mkv(1, 1, 2, 3,  7, 0,           1, 1, 0, 0, 0, 0, 0);
      tbl[6]  = mkv(0, 0, 0, 0,  0, 0,           1, 1, 0, 0, 0, 0, 0);
      tbl[7]  = mkv(0, 0, 0, 0,  0, 0,           1, 1, 1, 3, 0, 0, 0);
      tbl[8]  = mkv(0, 0, 0, 0,  0, 0,           1, 1, 1, 2, 1, 7, 128'h1234);
      tbl[9]  = mkv(0, 0, 0, 0,  0, 0,           1, 1, 0, 0, 0, 0, 0);
      tbl[10] = mkv(1, 1, 5, 15, 1, 0,           1, 1, 0, 0, 0, 0, 0);
      tbl[11] = mkv(0, 0, 0, 0,  0, 0,           1, 1, 0, 0, 0, 0, 0);
      tbl[12] = mkv(0, 0, 0, 0,  0, 0,           1, 1, 0, 0, 0, 0, 0);
      tbl[13] = mkv(0, 0, 0, 0,  0, 0,           0, 1, 1, 5, 1, 1, 0);
      tbl[14] = mkv(0, 0, 0, 0,  0, 0,           1, 1, 1, 5, 1, 1, 0);
      tbl[15] = mkv(0, 0, 0, 0,  0, 0,           1, 1, 0, 0, 0, 0, 0);

      @(negedge clk);
      do_reset();
      for (int i = 0; i < 16; i++) begin
         lsu_if.uop_valid_lsu_rvv2rvs = tbl[i].iv;
         lsu_if.uop_lsu_rvv2rvs       = mkreq(tbl[i].tag, tbl[i].ld, tbl[i].addr,
                                              tbl[i].vd, tbl[i].wd);
         lsu_if.uop_ready_rvv2rvs     = tbl[i].rr;
         #1;
         chk($sformatf("tbl%0d_ready", i), 256'(lsu_if.uop_ready_lsu_rvs2rvv), 256'(tbl[i].e_rdy));
         chk($sformatf("tbl%0d_valid", i), 256'(lsu_if.uop_valid_lsu_rvs2rvv), 256'(tbl[i].e_vld));
         if (tbl[i].e_vld) begin
            chk($sformatf("tbl%0d_tag", i),   256'(lsu_if.uop_lsu_rvs2rvv.tag),     256'(tbl[i].e_tag));
            chk($sformatf("tbl%0d_isld", i),  256'(lsu_if.uop_lsu_rvs2rvv.is_load), 256'(tbl[i].e_ld));
            chk($sformatf("tbl%0d_vd", i),    256'(lsu_if.uop_lsu_rvs2rvv.vd),      256'(tbl[i].e_vd));
            chk($sformatf("tbl%0d_rdata", i), 256'(lsu_if.uop_lsu_rvs2rvv.rdata),   256'(tbl[i].e_rd));
         end
         @(posedge clk);
         @(negedge clk);
      end

      // ---- backpressure: 6 requests with response ready held low
      do_reset();
      sent = 0;
      for (int c = 0; c < 4; c++) begin
         step(1, mkreq(4'(sent + 1), 0, 4'(sent), 0, rnd128()), 0, acc, dacc, dfire);
         if (acc) sent++;
      end
      #1;
      chk("ready_low_when_full", 256'(lsu_if.uop_ready_lsu_rvs2rvv), 256'(0));
      for (int c = 0; c < 20; c++)
         step(1, mkreq(4'(sent + 1), 1, 4'(sent), 2, 0), 0, acc, dacc, dfire);
      chk("hold_head_tag", 256'(lsu_if.uop_lsu_rvs2rvv.tag), 256'(1));
      fires = 0;
      for (int c = 0; c < 30 && (sent < 6 || q.size() != 0); c++) begin
         step(sent < 6, mkreq(4'(sent + 1), 1, 4'(sent), 2, 0), 1, acc, dacc, dfire);
         if (acc) sent++;
         if (dfire) fires++;
      end
      chk("backpressure_sent", 256'(sent), 256'(6));
      chk("backpressure_responses", 256'(fires), 256'(6));

      // ---- continuous stream of 32 requests with response ready high
      sent = 0; fires = 0; accs = 0;
      for (int c = 0; c < 32; c++) begin
         step(1, mkreq(4'(sent), $urandom_range(0, 1), 4'($urandom_range(0, 15)),
                       5'(c), rnd128()), 1, acc, dacc, dfire);
         if (acc) sent++;
         if (dacc) accs++;
         if (dfire) fires++;
      end
      chk("stream_accepts", 256'(accs), 256'(32));
      for (int c = 0; c < 10 && q.size() != 0; c++) begin
         step(0, idle, 1, acc, dacc, dfire);
         if (dfire) fires++;
      end
      chk("stream_responses", 256'(fires), 256'(32));

      // ---- reset with uops in flight
      step(1, mkreq(4'hA, 0, 5, 0, 128'hDEAD_BEEF), 1, acc, dacc, dfire);
      for (int c = 0; c < 6; c++) step(0, idle, 1, acc, dacc, dfire);
      for (int c = 0; c < 3; c++)
         step(1, mkreq(4'(c), 1, 5, 3, 0), 0, acc, dacc, dfire);
      #1;
      chk("inflight_valid_before_rst", 256'(lsu_if.uop_valid_lsu_rvs2rvv), 256'(1));
      do_reset();
      fires = 0;
      for (int c = 0; c < 8; c++) begin
         step(0, idle, 1, acc, dacc, dfire);
         if (dfire) fires++;
      end
      chk("no_stale_responses", 256'(fires), 256'(0));
      step(1, mkreq(4'hB, 1, 5, 9, 0), 1, acc, dacc, dfire);
      for (int c = 0; c < 6; c++) step(0, idle, 1, acc, dacc, dfire);

      // ---- randomized traffic
      for (int c = 0; c < 400; c++) begin
         step($urandom_range(0, 3) != 0,
              mkreq(4'($urandom), 1'($urandom), 4'($urandom_range(0, 15)),
                    5'($urandom), rnd128()),
              $urandom_range(0, 3) != 0, acc, dacc, dfire);
      end
      for (int c = 0; c < 20; c++) step(0, idle, 1, acc, dacc, dfire);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
